mitchell_lod_sched: RTL and testbench
=====================================

Name: mitchell_lod_sched

Overview:
- Sequencer that time-shares one external 8-bit leading-one detector (LOD) between the two operands of a Mitchell log multiplier.
- Accepts an operand pair over a valid/ready handshake and drives each operand to the shared LOD on successive cycles.
- Encodes each one-hot LOD result into a characteristic k and a normalised fraction, and presents both to the log-add stage over a second valid/ready handshake.
- Sits between the operand source and the Mitchell adder stage; the LOD itself stays combinational and outside this block.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported, to match the LOD.
- KW, 3, characteristic width; must equal log2(WIDTH).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operand pair valid.
- ready_o  output  1  block can accept an operand pair.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- lod_a_o  output  WIDTH  operand driven to the shared LOD input.
- lod_o_i  input  WIDTH  one-hot LOD result.
- lod_zero_i  input  1  LOD all-zero flag.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- ka_o  output  KW  characteristic of A.
- kb_o  output  KW  characteristic of B.
- fa_o  output  WIDTH-1  fraction of A.
- fb_o  output  WIDTH-1  fraction of B.
- zero_o  output  1  A or B is zero; the product is 0.

Behaviour:
- Reset (sync, rst_i=1 at a clock edge): state IDLE.
  - ready_o=1, valid_o=0.
  - ka_o, kb_o, fa_o, fb_o, zero_o all 0.
  - Operand registers 0, so lod_a_o=0.
  - Reset wins over every other event, including mid-operation: any in-flight pair is discarded and valid_o is 0 after that edge.
- States: IDLE, DET_A, DET_B, OUT. ready_o=1 only in IDLE, so there is no overlap between pairs.
- IDLE:
  - lod_a_o=0.
  - On valid_i&ready_o: capture a_i and b_i into opa_q and opb_q, then go to DET_A.
- DET_A:
  - lod_a_o=opa_q (combinational path through the LOD within the cycle).
  - At the clock edge:
    - register ka = index of the highest set bit of lod_o_i;
    - register fa = (opa_q << (7-ka))[6:0];
    - register za = lod_zero_i.
  - If lod_zero_i=1: early-out to OUT and skip DET_B, with kb=0 and fb=0.
  - Otherwise go to DET_B.
- DET_B:
  - lod_a_o=opb_q.
  - At the clock edge, register kb, fb and zb the same way, then go to OUT.
- OUT:
  - valid_o=1; zero_o=za|zb.
  - When zero_o=1, ka_o, kb_o, fa_o and fb_o all read 0 (forced at the output).
  - lod_a_o=0.
  - Hold all outputs stable while ready_i=0.
  - On ready_i=1: return to IDLE, with valid_o=0 on the next cycle.
- Latency, handshake cycle T:
  - normal pair: valid_o=1 in cycle T+3;
  - A zero: valid_o=1 in cycle T+2.
  - Throughput: one pair per 4 cycles, or 3 on early-out, plus any stall cycles.
- Malformed LOD result (more than one bit set on lod_o_i): encode the highest set bit. No error is flagged.
- lod_o_i nonzero while lod_zero_i=1: lod_zero_i takes priority, and k and f are 0.
- valid_i while not in IDLE: ignored. The source must hold valid_i until it sees ready_o.
- Width rule: the shift amount 7-ka is in the range 0..7. Bits shifted beyond bit 7 are dropped, and fa takes bits [6:0] only; the leading one is implicit.

Test Plan:
- Basic pair. A=8'h2C, B=8'h03 accepted at T.
  - lod_a_o=8'h2C in T+1, 8'h03 in T+2.
  - At T+3: ka_o=5, fa_o=7'h30, kb_o=1, fb_o=7'h40, zero_o=0, valid_o=1.
- Extremes. A=8'h80, B=8'h01 -> ka_o=7, fa_o=0, kb_o=0, fb_o=0, zero_o=0. A=8'hFF -> ka_o=7, fa_o=7'h7F.
- Early-out on zero A. A=0, B=8'h55.
  - LOD is never driven with 8'h55.
  - valid_o=1 at T+2 with zero_o=1 and all k/f=0.
  - Zero B instead: valid_o=1 at T+3 with zero_o=1 and all k/f=0.
- Backpressure. ready_i=0 for 5 cycles in OUT.
  - Outputs stay stable; ready_o=0 throughout; a second valid_i is ignored.
  - ready_i=1 -> IDLE on the next cycle; a new pair is accepted the cycle after.
- Reset mid-operation. Assert rst_i in DET_B.
  - After the edge: IDLE, ready_o=1, valid_o=0, all outputs 0.
  - A following pair A=8'h10, B=8'h10 gives ka_o=kb_o=4, fa_o=fb_o=0.
- Back-to-back stream. Issue 8 random nonzero pairs with ready_i=1 and compare against a reference model.
  - Each result lags its accept by exactly 3 cycles.
  - A new accept occurs exactly 4 cycles after the previous one.

Source files
------------

// File: rtl/mitchell_lod_sched_if.sv
// Bundle of the operand, shared-LOD and result handshakes of mitchell_lod_sched.
// The slave modport is the sequencer's view; master is the surrounding system.
interface mitchell_lod_sched_if #(
    parameter int WIDTH = 8,
    parameter int KW    = 3
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] lod_a_o;
    logic [WIDTH-1:0] lod_o_i;
    logic             lod_zero_i;
    logic             valid_o;
    logic             ready_i;
    logic [KW-1:0]    ka_o;
    logic [KW-1:0]    kb_o;
    logic [WIDTH-2:0] fa_o;
    logic [WIDTH-2:0] fb_o;
    logic             zero_o;

    modport slave (
        input  valid_i, a_i, b_i, lod_o_i, lod_zero_i, ready_i,
        output ready_o, lod_a_o, valid_o, ka_o, kb_o, fa_o, fb_o, zero_o
    );

    modport master (
        output valid_i, a_i, b_i, lod_o_i, lod_zero_i, ready_i,
        input  ready_o, lod_a_o, valid_o, ka_o, kb_o, fa_o, fb_o, zero_o
    );
endinterface

// File: rtl/mitchell_lod_sched.sv
// Time-shares one external 8-bit leading-one detector between both operands of a
// Mitchell log multiplier and presents characteristic/fraction pairs downstream.
module mitchell_lod_sched #(
    parameter int WIDTH = 8,
    parameter int KW    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    mitchell_lod_sched_if.slave   sif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DET_A = 2'd1,
        DET_B = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [KW-1:0] K_MAX = KW'(WIDTH - 1);

    // Malformed one-hot inputs resolve to their highest set bit.
    function automatic logic [KW-1:0] lod_encode(input logic [WIDTH-1:0] onehot);
        logic [KW-1:0] k;
        k = {KW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            k = onehot[i] ? KW'(i) : k;
        end
        return k;
    endfunction

    // Leading one is shifted out of the kept bits, so it stays implicit.
    function automatic logic [WIDTH-2:0] norm_frac(input logic [WIDTH-1:0] op,
                                                   input logic [KW-1:0]    k);
        logic [WIDTH-1:0] sh;
        sh = op << (K_MAX - k);
        return sh[WIDTH-2:0];
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [KW-1:0]    ka_q, ka_d, kb_q, kb_d;
    logic [WIDTH-2:0] fa_q, fa_d, fb_q, fb_d;
    logic             za_q, za_d, zb_q, zb_d;
    logic [KW-1:0]    lod_k;
    logic             out_zero;
    logic             out_data_en;

    assign lod_k = lod_encode(sif.lod_o_i);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            ka_q    <= {KW{1'b0}};
            kb_q    <= {KW{1'b0}};
            fa_q    <= {(WIDTH-1){1'b0}};
            fb_q    <= {(WIDTH-1){1'b0}};
            za_q    <= 1'b0;
            zb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            za_q    <= za_d;
            zb_q    <= zb_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ka_d    = ka_q;
        kb_d    = kb_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        za_d    = za_q;
        zb_d    = zb_q;
        case (state_q)
            IDLE: begin
                if (sif.valid_i) begin
                    // Clearing here makes an early-out leave kb/fb/zb at zero.
                    opa_d   = sif.a_i;
                    opb_d   = sif.b_i;
                    ka_d    = {KW{1'b0}};
                    kb_d    = {KW{1'b0}};
                    fa_d    = {(WIDTH-1){1'b0}};
                    fb_d    = {(WIDTH-1){1'b0}};
                    za_d    = 1'b0;
                    zb_d    = 1'b0;
                    state_d = DET_A;
                end else begin
                    state_d = IDLE;
                end
            end
            DET_A: begin
                if (sif.lod_zero_i) begin
                    ka_d    = {KW{1'b0}};
                    fa_d    = {(WIDTH-1){1'b0}};
                    za_d    = 1'b1;
                    state_d = OUT;
                end else begin
                    ka_d    = lod_k;
                    fa_d    = norm_frac(opa_q, lod_k);
                    za_d    = 1'b0;
                    state_d = DET_B;
                end
            end
            DET_B: begin
                if (sif.lod_zero_i) begin
                    kb_d = {KW{1'b0}};
                    fb_d = {(WIDTH-1){1'b0}};
                    zb_d = 1'b1;
                end else begin
                    kb_d = lod_k;
                    fb_d = norm_frac(opb_q, lod_k);
                    zb_d = 1'b0;
                end
                state_d = OUT;
            end
            OUT: begin
                if (sif.ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shared LOD input: only the operand under detection, zero otherwise.
    always_comb begin
        sif.lod_a_o = {WIDTH{1'b0}};
        case (state_q)
            DET_A:   sif.lod_a_o = opa_q;
            DET_B:   sif.lod_a_o = opb_q;
            default: sif.lod_a_o = {WIDTH{1'b0}};
        endcase
    end

    // Result fields read zero outside OUT and whenever the product is zero.
    assign out_zero     = (state_q == OUT) && (za_q || zb_q);
    assign out_data_en  = (state_q == OUT) && !(za_q || zb_q);
    assign sif.ready_o  = (state_q == IDLE);
    assign sif.valid_o  = (state_q == OUT);
    assign sif.zero_o   = out_zero;
    assign sif.ka_o     = out_data_en ? ka_q : {KW{1'b0}};
    assign sif.kb_o     = out_data_en ? kb_q : {KW{1'b0}};
    assign sif.fa_o     = out_data_en ? fa_q : {(WIDTH-1){1'b0}};
    assign sif.fb_o     = out_data_en ? fb_q : {(WIDTH-1){1'b0}};
endmodule

// File: tb/tb_mitchell_lod_sched.sv
// Scoreboard bench for mitchell_lod_sched with a behavioural LOD that can be made
// to return multi-bit results or a forced zero flag.
module tb_mitchell_lod_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lod_mode = 0;   // 0 clean one-hot, 1 raw operand, 2 forced zero flag

    typedef struct {
        logic [2:0] ka;
        logic [2:0] kb;
        logic [6:0] fa;
        logic [6:0] fb;
        logic       zero;
        int         acc;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int         acc_cyc = -10;
    logic [7:0] acc_a = 8'd0;
    logic [7:0] acc_b = 8'd0;
    logic       acc_early = 1'b0;
    logic       in_out = 1'b0;

    mitchell_lod_sched_if #(.WIDTH(8), .KW(3)) bus ();

    mitchell_lod_sched #(.WIDTH(8), .KW(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sif   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural shared LOD.
    always_comb begin
        logic [7:0] oh;
        oh = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.lod_a_o[i]) oh = 8'd1 << i;
        end
        bus.lod_o_i    = (lod_mode == 1) ? bus.lod_a_o : oh;
        bus.lod_zero_i = (lod_mode == 2) ? 1'b1 : (bus.lod_a_o == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [2:0] ref_k(input logic [7:0] v);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) k = 3'(i);
        end
        return k;
    endfunction

    function automatic logic [6:0] ref_f(input logic [7:0] v);
        logic [2:0] k;
        logic [7:0] t;
        k = ref_k(v);
        t = v & ~(8'd1 << k);
        t = t << (3'd7 - k);
        return t[6:0];
    endfunction

    // Monitor: scoreboard push on accept, compare while a result is presented.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            in_out = 1'b0;
        end else begin
            if (bus.ready_o) check("lod_idle", bus.lod_a_o, 8'd0);
            else if (cyc == acc_cyc + 1) check("lod_a", bus.lod_a_o, acc_a);
            else if (cyc == acc_cyc + 2) check("lod_b", bus.lod_a_o, acc_early ? 8'd0 : acc_b);

            if (bus.valid_i && bus.ready_o) begin
                exp_t e;
                logic early, zb;
                early  = (bus.a_i == 8'd0) || (lod_mode == 2);
                zb     = !early && (bus.b_i == 8'd0);
                e.zero = early || zb;
                e.ka   = e.zero ? 3'd0 : ref_k(bus.a_i);
                e.kb   = e.zero ? 3'd0 : ref_k(bus.b_i);
                e.fa   = e.zero ? 7'd0 : ref_f(bus.a_i);
                e.fb   = e.zero ? 7'd0 : ref_f(bus.b_i);
                e.acc  = cyc;
                e.lat  = early ? 2 : 3;
                sb.push_back(e);
                acc_cyc   = cyc;
                acc_a     = bus.a_i;
                acc_b     = bus.b_i;
                acc_early = early;
            end

            if (bus.valid_o) begin
                check("ready_in_out", bus.ready_o, 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_valid", bus.valid_o, 1'b0);
                end else begin
                    check("ka", bus.ka_o, sb[0].ka);
                    check("kb", bus.kb_o, sb[0].kb);
                    check("fa", bus.fa_o, sb[0].fa);
                    check("fb", bus.fb_o, sb[0].fb);
                    check("zero", bus.zero_o, sb[0].zero);
                    if (!in_out) check("latency", cyc - sb[0].acc, sb[0].lat);
                    in_out = 1'b1;
                    if (bus.ready_i) begin
                        void'(sb.pop_front());
                        in_out = 1'b0;
                    end
                end
            end else begin
                in_out = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        bus.valid_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                acc = cyc;
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && bus.ready_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, bus.ready_o, 1'b1);
        check({tag, "_valid"}, bus.valid_o, 1'b0);
        check({tag, "_k"}, {bus.ka_o, bus.kb_o}, 6'd0);
        check({tag, "_f"}, {bus.fa_o, bus.fb_o}, 14'd0);
        check({tag, "_zero"}, bus.zero_o, 1'b0);
        check({tag, "_lod"}, bus.lod_a_o, 8'd0);
    endtask

    initial begin
        int acc, prev, r;
        bit seen;
        bus.valid_i = 1'b0;
        bus.a_i     = 8'd0;
        bus.b_i     = 8'd0;
        bus.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        send(8'h2C, 8'h03, acc);
        drain();
        send(8'h80, 8'h01, acc);
        send(8'hFF, 8'h41, acc);
        drain();
        send(8'h00, 8'h55, acc);
        send(8'h37, 8'h00, acc);
        drain();

        lod_mode = 1;
        send(8'h2C, 8'h96, acc);
        drain();
        lod_mode = 2;
        send(8'h5A, 8'h33, acc);
        drain();
        lod_mode = 0;

        // Backpressure with a competing request held during the stall.
        bus.ready_i = 1'b0;
        send(8'hA3, 8'h1C, acc);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("bp_valid_seen", seen, 1'b1);
        bus.valid_i = 1'b1;
        bus.a_i     = 8'h77;
        bus.b_i     = 8'h11;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_ready_low", bus.ready_o, 1'b0);
            check("bp_valid_held", bus.valid_o, 1'b1);
        end
        bus.ready_i = 1'b1;
        r = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check("bp_reaccept_cycle", acc_cyc, r + 1);
        drain();

        // Reset while operand B is in the LOD.
        send(8'h21, 8'h42, acc);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("midrst");
        send(8'h10, 8'h10, acc);
        drain();

        prev = 0;
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), acc);
            if (i > 0) check("stream_gap", acc - prev, 4);
            prev = acc;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
